instruction_fetcher: RTL and testbench

- Per-warp fetch stage that sits directly upstream of the decode stage.
- When the warp scheduler enters WARP_FETCH, it issues one read request for the instruction at `pc` to program memory through a valid/ready handshake.
- It latches the returned word on `instruction` and holds it stable through WARP_DECODE so the decoder can sample it.
- Supports a `flush` from branch/JAL redirect that discards an in-flight fetch.

---
 rtl/instruction_fetcher.sv | 169 ++++++++++++++++
 tb/tb_instruction_fetcher.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// Per-warp instruction fetch stage feeding the decoder.
// Issues one valid/ready read to program memory per WARP_FETCH, latches the
// returned word on `instruction` and holds it through WARP_DECODE. A redirect
// flush discards an in-flight fetch, but a request is never withdrawn before
// memory answers.
// Optional: define INSTRUCTION_FETCHER_REUSE_EN to add a one-entry reuse
// buffer. A repeat fetch of the last completed pc then skips memory.

package instruction_fetcher_pkg;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  typedef enum logic [1:0] {
    FETCHER_IDLE     = 2'd0,
    FETCHER_FETCHING = 2'd1,
    FETCHER_DONE     = 2'd2,
    FETCHER_FLUSHING = 2'd3
  } fetcher_state_t;

endpackage

module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int PROGRAM_ADDR_WIDTH = 32,
  parameter int INSTRUCTION_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  warp_state_t                   warp_state,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] pc,
  input  logic                          flush,
  output logic                          mem_read_valid,
  output logic [PROGRAM_ADDR_WIDTH-1:0] mem_read_address,
  input  logic                          mem_read_ready,
  input  logic [INSTRUCTION_WIDTH-1:0]  mem_read_data,
  output fetcher_state_t                fetcher_state,
  output logic [INSTRUCTION_WIDTH-1:0]  instruction,
  output logic [15:0]                   fetch_count
);

  fetcher_state_t                state_q, state_d;
  logic                          valid_q, valid_d;
  logic [PROGRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INSTRUCTION_WIDTH-1:0]  instr_q, instr_d;
  logic [15:0]                   count_q, count_d;
  logic                          reuse_hit;

`ifdef INSTRUCTION_FETCHER_REUSE_EN
  logic [PROGRAM_ADDR_WIDTH-1:0] last_pc_q, last_pc_d;
  logic                          last_valid_q, last_valid_d;

  // A repeat fetch of the last completed address can be served locally.
  assign reuse_hit = last_valid_q && (pc == last_pc_q);
`else
  assign reuse_hit = 1'b0;
`endif

  // Next-state and next-output logic for the fetch handshake.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path leaves it unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    count_d = count_q;
`ifdef INSTRUCTION_FETCHER_REUSE_EN
    last_pc_d    = last_pc_q;
    last_valid_d = flush ? 1'b0 : last_valid_q;
`endif

    case (state_q)
      FETCHER_IDLE: begin
        if (warp_state == WARP_FETCH && !flush) begin
          if (reuse_hit) begin
            // Served from the reuse buffer: instruction already holds the word.
            state_d = FETCHER_DONE;
            count_d = count_q + 16'd1;
          end else begin
            state_d = FETCHER_FETCHING;
            valid_d = 1'b1;
            addr_d  = pc;
          end
        end
      end

      FETCHER_FETCHING: begin
        // Request stays frozen; pc changes are ignored until the next request.
        if (mem_read_ready && !flush) begin
          state_d = FETCHER_DONE;
          valid_d = 1'b0;
          instr_d = mem_read_data;
          count_d = count_q + 16'd1;
`ifdef INSTRUCTION_FETCHER_REUSE_EN
          last_pc_d    = addr_q;
          last_valid_d = 1'b1;
`endif
        end else if (flush && mem_read_ready) begin
          state_d = FETCHER_IDLE;
          valid_d = 1'b0;
        end else if (flush) begin
          state_d = FETCHER_FLUSHING;
        end
      end

      FETCHER_FLUSHING: begin
        // Keep the request up until memory answers, then drop the data.
        if (mem_read_ready) begin
          state_d = FETCHER_IDLE;
          valid_d = 1'b0;
        end
      end

      FETCHER_DONE: begin
        // Decoder samples instruction during WARP_DECODE; flush leaves it stale.
        if (flush || warp_state == WARP_DECODE) begin
          state_d = FETCHER_IDLE;
        end
      end

      default: begin
        state_d = FETCHER_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      state_q <= FETCHER_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      count_q <= '0;
`ifdef INSTRUCTION_FETCHER_REUSE_EN
      last_pc_q    <= '0;
      last_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      count_q <= count_d;
`ifdef INSTRUCTION_FETCHER_REUSE_EN
      last_pc_q    <= last_pc_d;
      last_valid_q <= last_valid_d;
`endif
    end
  end

  assign fetcher_state    = state_q;
  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign instruction      = instr_q;
  assign fetch_count      = count_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed testbench for instruction_fetcher with immediate assertions.
// Inputs change 1 time unit after a rising edge. Outputs are checked at that
// same point, so they reflect the edge just taken.
module tb_instruction_fetcher;
  import instruction_fetcher_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  warp_state_t    warp_state;
  logic [31:0]    pc;
  logic           flush;
  logic           mem_read_valid;
  logic [31:0]    mem_read_address;
  logic           mem_read_ready;
  logic [31:0]    mem_read_data;
  fetcher_state_t fetcher_state;
  logic [31:0]    instruction;
  logic [15:0]    fetch_count;

  int vectors = 0;
  int errors  = 0;

  instruction_fetcher #(
    .PROGRAM_ADDR_WIDTH(32),
    .INSTRUCTION_WIDTH (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .warp_state      (warp_state),
    .pc              (pc),
    .flush           (flush),
    .mem_read_valid  (mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .fetcher_state   (fetcher_state),
    .instruction     (instruction),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input fetcher_state_t st, input logic v,
                           input logic [31:0] a, input logic [31:0] ins, input logic [15:0] cnt);
    check({tag, ".state"}, 64'(fetcher_state), 64'(st));
    check({tag, ".valid"}, 64'(mem_read_valid), 64'(v));
    check({tag, ".addr"},  64'(mem_read_address), 64'(a));
    check({tag, ".instr"}, 64'(instruction), 64'(ins));
    check({tag, ".count"}, 64'(fetch_count), 64'(cnt));
  endtask

  initial begin
    reset = 1'b1; warp_state = WARP_IDLE; pc = '0; flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = '0;
    step(); step();
    check_all("reset", FETCHER_IDLE, 1'b0, 32'h0, 32'h0, 16'd0);

    // Basic fetch, ready one cycle after the request.
    reset = 1'b0; pc = 32'h10; warp_state = WARP_FETCH;
    step();
    check_all("basic_req", FETCHER_FETCHING, 1'b1, 32'h10, 32'h0, 16'd0);
    warp_state = WARP_WAIT; mem_read_ready = 1'b1; mem_read_data = 32'h2000_0123;
    step();
    check_all("basic_done", FETCHER_DONE, 1'b0, 32'h10, 32'h2000_0123, 16'd1);
    // Ready while DONE is ignored.
    mem_read_data = 32'hFFFF_0000;
    step();
    check_all("done_ready_ign", FETCHER_DONE, 1'b0, 32'h10, 32'h2000_0123, 16'd1);
    mem_read_ready = 1'b0; warp_state = WARP_DECODE;
    step();
    check_all("basic_decode", FETCHER_IDLE, 1'b0, 32'h10, 32'h2000_0123, 16'd1);
    // Ready while IDLE is ignored.
    warp_state = WARP_IDLE; mem_read_ready = 1'b1; mem_read_data = 32'h1234_5678;
    step();
    check_all("idle_ready_ign", FETCHER_IDLE, 1'b0, 32'h10, 32'h2000_0123, 16'd1);
    mem_read_ready = 1'b0;

    // Wait states: ready after 5 extra cycles, pc changes mid-wait.
    pc = 32'h30; warp_state = WARP_FETCH;
    step();
    check_all("wait_req", FETCHER_FETCHING, 1'b1, 32'h30, 32'h2000_0123, 16'd1);
    warp_state = WARP_WAIT; pc = 32'h20;
    for (int i = 0; i < 5; i++) begin
      step();
      check("wait_hold.valid", 64'(mem_read_valid), 64'(1));
      check("wait_hold.addr",  64'(mem_read_address), 64'h30);
    end
    mem_read_ready = 1'b1; mem_read_data = 32'h1111_2222;
    step();
    check_all("wait_done", FETCHER_DONE, 1'b0, 32'h30, 32'h1111_2222, 16'd2);
    mem_read_ready = 1'b0; warp_state = WARP_DECODE;
    step();
    check("wait_decode.state", 64'(fetcher_state), 64'(FETCHER_IDLE));

    // Flush in IDLE blocks a new request.
    pc = 32'h50; warp_state = WARP_FETCH; flush = 1'b1;
    step();
    check_all("idle_flush", FETCHER_IDLE, 1'b0, 32'h30, 32'h1111_2222, 16'd2);
    flush = 1'b0;

    // Flush while waiting: FLUSHING, extra flush ignored, data discarded.
    step();
    check_all("fl_req", FETCHER_FETCHING, 1'b1, 32'h50, 32'h1111_2222, 16'd2);
    warp_state = WARP_WAIT; flush = 1'b1;
    step();
    check_all("fl_flushing", FETCHER_FLUSHING, 1'b1, 32'h50, 32'h1111_2222, 16'd2);
    flush = 1'b0;
    step();
    flush = 1'b1;
    step();
    check_all("fl_refl", FETCHER_FLUSHING, 1'b1, 32'h50, 32'h1111_2222, 16'd2);
    flush = 1'b0; mem_read_ready = 1'b1; mem_read_data = 32'hDEAD_BEEF;
    step();
    check_all("fl_idle", FETCHER_IDLE, 1'b0, 32'h50, 32'h1111_2222, 16'd2);
    mem_read_ready = 1'b0;

    // Flush and ready in the same cycle: straight to IDLE.
    pc = 32'h60; warp_state = WARP_FETCH;
    step();
    check_all("flr_req", FETCHER_FETCHING, 1'b1, 32'h60, 32'h1111_2222, 16'd2);
    warp_state = WARP_WAIT; flush = 1'b1; mem_read_ready = 1'b1; mem_read_data = 32'h0BAD_0BAD;
    step();
    check_all("flr_idle", FETCHER_IDLE, 1'b0, 32'h60, 32'h1111_2222, 16'd2);
    flush = 1'b0; mem_read_ready = 1'b0;

    // Flush in DONE: back to IDLE, instruction retained.
    pc = 32'h70; warp_state = WARP_FETCH;
    step();
    warp_state = WARP_WAIT; mem_read_ready = 1'b1; mem_read_data = 32'h7070_7070;
    step();
    check_all("dfl_done", FETCHER_DONE, 1'b0, 32'h70, 32'h7070_7070, 16'd3);
    mem_read_ready = 1'b0; flush = 1'b1;
    step();
    check_all("dfl_idle", FETCHER_IDLE, 1'b0, 32'h70, 32'h7070_7070, 16'd3);
    flush = 1'b0;

    // Reset mid-fetch; a late ready is ignored.
    pc = 32'h80; warp_state = WARP_FETCH;
    step();
    check("rst_req.state", 64'(fetcher_state), 64'(FETCHER_FETCHING));
    reset = 1'b1; warp_state = WARP_WAIT;
    step();
    check_all("rst_mid", FETCHER_IDLE, 1'b0, 32'h0, 32'h0, 16'd0);
    reset = 1'b0; mem_read_ready = 1'b1; mem_read_data = 32'h8888_8888;
    step();
    check_all("rst_late", FETCHER_IDLE, 1'b0, 32'h0, 32'h0, 16'd0);
    mem_read_ready = 1'b0;

    // Repeat fetch of the same pc.
    pc = 32'h40; warp_state = WARP_FETCH;
    step();
    warp_state = WARP_WAIT; mem_read_ready = 1'b1; mem_read_data = 32'h4040_4040;
    step();
    check_all("rep1_done", FETCHER_DONE, 1'b0, 32'h40, 32'h4040_4040, 16'd1);
    mem_read_ready = 1'b0; warp_state = WARP_DECODE;
    step();
    warp_state = WARP_FETCH;
    step();
`ifdef INSTRUCTION_FETCHER_REUSE_EN
    check_all("rep2_hit", FETCHER_DONE, 1'b0, 32'h40, 32'h4040_4040, 16'd2);
`else
    check_all("rep2_req", FETCHER_FETCHING, 1'b1, 32'h40, 32'h4040_4040, 16'd1);
    warp_state = WARP_WAIT; mem_read_ready = 1'b1;
    step();
    check_all("rep2_done", FETCHER_DONE, 1'b0, 32'h40, 32'h4040_4040, 16'd2);
    mem_read_ready = 1'b0;
`endif
    warp_state = WARP_DECODE;
    step();
    // A flush invalidates any reused entry; the same pc must hit memory.
    warp_state = WARP_IDLE; flush = 1'b1;
    step();
    flush = 1'b0; warp_state = WARP_FETCH;
    step();
    check_all("rep3_req", FETCHER_FETCHING, 1'b1, 32'h40, 32'h4040_4040, 16'd2);
    warp_state = WARP_WAIT; mem_read_ready = 1'b1; mem_read_data = 32'h4141_4141;
    step();
    check_all("rep3_done", FETCHER_DONE, 1'b0, 32'h40, 32'h4141_4141, 16'd3);
    mem_read_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
